sap_1_controller_sequencer: RTL and testbench
=============================================

Name: sap_1_controller_sequencer

Overview:
Controller-sequencer for the SAP-1 datapath: the block that drives the memory address register (MAR), ROM, instruction register (IR), accumulator, adder/subtractor, B register and output register.
- Six-state one-hot ring counter (T1..T6) combined with opcode decode produces the 12-bit control word each cycle.
- T1..T3 fetch through MAR/ROM into IR; T4..T6 execute LDA/ADD/SUB/OUT; HLT freezes the machine.

Parameters:
OPCODE_W, 4, opcode width (IR upper nibble)
RING_N, 6, number of T-states; only 6 is supported

Ports:
Clk  input  1  system clock; all state changes on rising edge
Clr  input  1  synchronous, active-high reset
opcode  input  4  IR[7:4]; valid during T4..T6
control_word  output  12  {Cp,Ep,LMbar,CEbar,LIbar,EIbar,LAbar,EA,Su,EU,LBbar,LObar}, bit 11 = Cp
t_state  output  6  one-hot ring state; bit 0 = T1
halt  output  1  high once HLT has executed
illegal_op  output  1  undefined opcode trapped (macro-dependent)

Behaviour:
- Reset (Clr=1 at a rising edge):
  - t_state=6'b000001, halt=0, illegal_op=0.
  - Clr has priority over every other event, including mid-instruction and while halted.
- Ring: each rising edge with Clr=0 and halt=0 rotates t_state left; T6 wraps to T1. The ring is always exactly one-hot.
- control_word is combinational from t_state and opcode, with zero latency. Idle word = 12'h3E3, all loads/enables inactive.
- Fetch, independent of opcode:
  - T1 = 12'h5E3 (Ep, LMbar)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (CEbar, LIbar)
- Execute (T4/T5/T6):
  - LDA 4'h0: 1A3 / 2C3 / 3E3
  - ADD 4'h1: 1A3 / 2E1 / 3C7
  - SUB 4'h2: 1A3 / 2E1 / 3CF
  - OUT 4'hE: 3F2 / 3E3 / 3E3
- HLT 4'hF:
  - In T4, control_word = 3E3.
  - halt sets at the rising edge ending T4; the ring stays in T4.
  - While halt=1: control_word = 3E3 and t_state frozen. Only Clr clears halt.
- Undefined opcodes (3..D):
  - Without the macro: treated as NOP, 3E3 in T4..T6, ring continues.
- opcode changes during T1..T3 do not affect control_word.
- Never assert both Cp-related and load-enable bits outside the values listed above. Any other combination is a design error.

Optional Feature:
SAP_1_CTRL_ILLEGAL_TRAP_EN
- Defined: an undefined opcode in T4 sets illegal_op and halt at the end of T4. The ring freezes in T4 with control_word 3E3; Clr clears both flags.
- Undefined: illegal_op is tied to 0 and undefined opcodes behave as NOP.

Decomposition:
- Shared header sap_1_ctrl_defs.vh, with include guard, contains:
  - opcode constants (LDA/ADD/SUB/OUT/HLT)
  - control-word bit indices
  - named control-word constants (CW_IDLE=12'h3E3, CW_T1, CW_T2, CW_T3, ...)
  - T-state one-hot constants
- Sub-module sap_1_ring_counter (Clk, Clr, hold, t_state[5:0]) implements the one-hot ring with hold.
- The top level does opcode decode and the halt/trap flags.

Test Plan:
1. Clr=1 for 2 cycles, then release -> t_state=000001, control_word=5E3, halt=0. Following cycles give BE3, 263, in that order.
2. opcode=0 (LDA) across one full instruction -> T1..T6 sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then wraps to T1 (5E3).
3. opcode=1 then opcode=2 on consecutive instructions -> T6 shows 3C7 for ADD and 3CF for SUB. opcode=E -> T4 shows 3F2.
4. opcode=F -> T4 word 3E3; after the next edge halt=1, t_state=001000 held for 10+ cycles. Clr -> t_state=000001, halt=0.
5. Clr asserted in T5 of an ADD -> next edge t_state=000001, control_word=5E3, no 2E1/3C7 emitted afterward.
6. opcode=5:
   - Macro off: T4..T6 all 3E3 and the ring continues.
   - Macro on: illegal_op=1 and halt=1 after T4, frozen until Clr.

Source files
------------

// File: rtl/sap_1_controller_sequencer_pkg.sv
// Shared SAP-1 controller definitions: opcodes, control-word bit indices and values, T-state codes.
// Used by both the top level and the ring counter. The optional SAP_1_CTRL_ILLEGAL_TRAP_EN
// macro is consumed by the top level only.
`ifndef SAP_1_CTRL_DEFS_VH
`define SAP_1_CTRL_DEFS_VH
package sap_1_controller_sequencer_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // control_word = {Cp,Ep,LMbar,CEbar,LIbar,EIbar,LAbar,EA,Su,EU,LBbar,LObar}
  localparam int CW_CP_B    = 11;
  localparam int CW_EP_B    = 10;
  localparam int CW_LMBAR_B = 9;
  localparam int CW_CEBAR_B = 8;
  localparam int CW_LIBAR_B = 7;
  localparam int CW_EIBAR_B = 6;
  localparam int CW_LABAR_B = 5;
  localparam int CW_EA_B    = 4;
  localparam int CW_SU_B    = 3;
  localparam int CW_EU_B    = 2;
  localparam int CW_LBBAR_B = 1;
  localparam int CW_LOBAR_B = 0;

  localparam logic [11:0] CW_IDLE    = 12'h3E3;
  localparam logic [11:0] CW_T1      = 12'h5E3;
  localparam logic [11:0] CW_T2      = 12'hBE3;
  localparam logic [11:0] CW_T3      = 12'h263;
  localparam logic [11:0] CW_MEM_T4  = 12'h1A3;
  localparam logic [11:0] CW_LDA_T5  = 12'h2C3;
  localparam logic [11:0] CW_ALU_T5  = 12'h2E1;
  localparam logic [11:0] CW_ADD_T6  = 12'h3C7;
  localparam logic [11:0] CW_SUB_T6  = 12'h3CF;
  localparam logic [11:0] CW_OUT_T4  = 12'h3F2;

  localparam logic [5:0] T1_OH = 6'b000001;
  localparam logic [5:0] T2_OH = 6'b000010;
  localparam logic [5:0] T3_OH = 6'b000100;
  localparam logic [5:0] T4_OH = 6'b001000;
  localparam logic [5:0] T5_OH = 6'b010000;
  localparam logic [5:0] T6_OH = 6'b100000;

  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage
`endif

// File: rtl/sap_1_controller_sequencer_ring_counter.sv
// Six-state one-hot T-state ring with hold; Clr forces T1 regardless of hold.
module sap_1_ring_counter
  import sap_1_controller_sequencer_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic       hold,
  output logic [5:0] t_state
);

  logic [5:0] t_q, t_d;

  always_comb begin
    t_d = t_q;
    if (!hold) t_d = {t_q[4:0], t_q[5]};
  end

  always_ff @(posedge Clk) begin
    if (Clr) t_q <= T1_OH;
    else     t_q <= t_d;
  end

  assign t_state = t_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: opcode decode into the 12-bit control word plus halt/trap flags.
// Optional SAP_1_CTRL_ILLEGAL_TRAP_EN: undefined opcodes in T4 trap (illegal_op + halt).
module sap_1_controller_sequencer
  import sap_1_controller_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int RING_N   = 6
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [11:0]         control_word,
  output logic [RING_N-1:0]   t_state,
  output logic                halt,
  output logic                illegal_op
);

  logic halt_q, halt_d;
  logic in_t4;
  logic halt_set;
  logic trap_set;
  logic hold;
  logic [11:0] cw;

  sap_1_ring_counter u_ring (
    .Clk     (Clk),
    .Clr     (Clr),
    .hold    (hold),
    .t_state (t_state)
  );

  assign in_t4    = (t_state == T4_OH) && !halt_q;
  assign halt_set = in_t4 && (opcode == OP_HLT);

`ifdef SAP_1_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign trap_set  = in_t4 && !is_defined_op(opcode);
  assign illegal_d = illegal_q | trap_set;

  always_ff @(posedge Clk) begin
    if (Clr) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign trap_set   = 1'b0;
  assign illegal_op = 1'b0;
`endif

  // Hold must already be active on the edge that sets halt so the ring stays in T4.
  assign hold   = halt_q | halt_set | trap_set;
  assign halt_d = halt_q | halt_set | trap_set;

  always_ff @(posedge Clk) begin
    if (Clr) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end

  always_comb begin
    cw = CW_IDLE;
    if (!halt_q) begin
      case (t_state)
        T1_OH: cw = CW_T1;
        T2_OH: cw = CW_T2;
        T3_OH: cw = CW_T3;
        T4_OH: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: cw = CW_MEM_T4;
            OP_OUT:                 cw = CW_OUT_T4;
            default:                cw = CW_IDLE;
          endcase
        end
        T5_OH: begin
          case (opcode)
            OP_LDA:         cw = CW_LDA_T5;
            OP_ADD, OP_SUB: cw = CW_ALU_T5;
            default:        cw = CW_IDLE;
          endcase
        end
        T6_OH: begin
          case (opcode)
            OP_ADD:  cw = CW_ADD_T6;
            OP_SUB:  cw = CW_SUB_T6;
            default: cw = CW_IDLE;
          endcase
        end
        default: cw = CW_IDLE;
      endcase
    end
  end

  assign control_word = cw;
  assign halt         = halt_q;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Bench for sap_1_controller_sequencer: directed vector table, then random opcodes vs a step-count model.
module tb_sap_1_controller_sequencer;

  logic        Clk;
  logic        Clr;
  logic [3:0]  opcode;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halt;
  logic        illegal_op;

  int checks;
  int failures;

  sap_1_controller_sequencer #(.OPCODE_W(4), .RING_N(6)) dut (
    .Clk          (Clk),
    .Clr          (Clr),
    .opcode       (opcode),
    .control_word (control_word),
    .t_state      (t_state),
    .halt         (halt),
    .illegal_op   (illegal_op)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        clr;
    logic [3:0]  op;
    logic [11:0] cw;
    logic [5:0]  t;
    logic        h;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  // Execute-phase words indexed by opcode and (step-4); unlisted opcodes stay idle.
  logic [11:0] exec_tbl [16][3];

  function automatic void add(input logic clr, input logic [3:0] op, input logic [11:0] cw,
                              input logic [5:0] t, input logic h, input logic ill);
    vec_t v;
    v.clr = clr; v.op = op; v.cw = cw; v.t = t; v.h = h; v.ill = ill;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [11:0] cw, input logic [5:0] t,
                         input logic h, input logic ill);
    chk({tag, ".control_word"}, control_word, cw);
    chk({tag, ".t_state"}, {6'd0, t_state}, {6'd0, t});
    chk({tag, ".halt"}, {11'd0, halt}, {11'd0, h});
    chk({tag, ".illegal_op"}, {11'd0, illegal_op}, {11'd0, ill});
  endtask

  function automatic logic [11:0] model_cw(input int step, input logic [3:0] op, input bit h);
    if (h) return 12'h3E3;
    case (step)
      1: return 12'h5E3;
      2: return 12'hBE3;
      3: return 12'h263;
      default: return exec_tbl[op][step-4];
    endcase
  endfunction

  int  m_step;
  bit  m_halt;
  bit  m_ill;

  initial begin
    checks = 0;
    failures = 0;
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) exec_tbl[o][s] = 12'h3E3;
    exec_tbl[0] = '{12'h1A3, 12'h2C3, 12'h3E3};
    exec_tbl[1] = '{12'h1A3, 12'h2E1, 12'h3C7};
    exec_tbl[2] = '{12'h1A3, 12'h2E1, 12'h3CF};
    exec_tbl[14] = '{12'h3F2, 12'h3E3, 12'h3E3};

    // LDA full instruction
    add(0, 4'h0, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'h0, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'h0, 12'h263, 6'h04, 0, 0);
    add(0, 4'h0, 12'h1A3, 6'h08, 0, 0);
    add(0, 4'h0, 12'h2C3, 6'h10, 0, 0);
    add(0, 4'h0, 12'h3E3, 6'h20, 0, 0);
    // ADD
    add(0, 4'h1, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'h1, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'h1, 12'h263, 6'h04, 0, 0);
    add(0, 4'h1, 12'h1A3, 6'h08, 0, 0);
    add(0, 4'h1, 12'h2E1, 6'h10, 0, 0);
    add(0, 4'h1, 12'h3C7, 6'h20, 0, 0);
    // SUB, with an HLT opcode present during fetch that must be ignored
    add(0, 4'hF, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'hF, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'hF, 12'h263, 6'h04, 0, 0);
    add(0, 4'h2, 12'h1A3, 6'h08, 0, 0);
    add(0, 4'h2, 12'h2E1, 6'h10, 0, 0);
    add(0, 4'h2, 12'h3CF, 6'h20, 0, 0);
    // OUT
    add(0, 4'hE, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'hE, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'hE, 12'h263, 6'h04, 0, 0);
    add(0, 4'hE, 12'h3F2, 6'h08, 0, 0);
    add(0, 4'hE, 12'h3E3, 6'h10, 0, 0);
    add(0, 4'hE, 12'h3E3, 6'h20, 0, 0);
    // HLT, then held for 11 cycles with opcode wiggling, then cleared
    add(0, 4'hF, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'hF, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'hF, 12'h263, 6'h04, 0, 0);
    add(0, 4'hF, 12'h3E3, 6'h08, 0, 0);
    for (int i = 0; i < 11; i++)
      add(0, (i % 2) ? 4'hF : 4'h1, 12'h3E3, 6'h08, 1, 0);
    add(1, 4'hF, 12'h3E3, 6'h08, 1, 0);
    add(0, 4'h0, 12'h5E3, 6'h01, 0, 0);
    // undefined opcode 5
    add(0, 4'h5, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'h5, 12'h263, 6'h04, 0, 0);
    add(0, 4'h5, 12'h3E3, 6'h08, 0, 0);
`ifdef SAP_1_CTRL_ILLEGAL_TRAP_EN
    add(0, 4'h5, 12'h3E3, 6'h08, 1, 1);
    add(0, 4'h5, 12'h3E3, 6'h08, 1, 1);
    add(0, 4'h0, 12'h3E3, 6'h08, 1, 1);
    add(1, 4'h5, 12'h3E3, 6'h08, 1, 1);
`else
    add(0, 4'h5, 12'h3E3, 6'h10, 0, 0);
    add(0, 4'h5, 12'h3E3, 6'h20, 0, 0);
`endif
    // Clr in T5 of an ADD: refetch follows, no stale 2E1/3C7
    add(0, 4'h1, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'h1, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'h1, 12'h263, 6'h04, 0, 0);
    add(0, 4'h1, 12'h1A3, 6'h08, 0, 0);
    add(1, 4'h1, 12'h2E1, 6'h10, 0, 0);
    add(0, 4'h1, 12'h5E3, 6'h01, 0, 0);
    add(0, 4'h1, 12'hBE3, 6'h02, 0, 0);
    add(0, 4'h1, 12'h263, 6'h04, 0, 0);
    add(0, 4'h1, 12'h1A3, 6'h08, 0, 0);
    add(0, 4'h1, 12'h2E1, 6'h10, 0, 0);
    add(0, 4'h1, 12'h3C7, 6'h20, 0, 0);

    // Reset held for two edges
    Clr = 1'b1;
    opcode = 4'h0;
    repeat (2) @(posedge Clk);
    #1;

    foreach (vecs[i]) begin
      Clr = vecs[i].clr;
      opcode = vecs[i].op;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].cw, vecs[i].t, vecs[i].h, vecs[i].ill);
      @(posedge Clk);
      #1;
    end

    // Random phase against the step-count model
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    m_step = 1;
    m_halt = 0;
    m_ill = 0;
    for (int n = 0; n < 800; n++) begin
      logic [3:0] op;
      logic       clr;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
      clr = ($urandom_range(0, 24) == 0);
      Clr = clr;
      opcode = op;
      #1;
      chk_all($sformatf("rnd%0d", n), model_cw(m_step, op, m_halt),
              6'(1) << (m_step - 1), m_halt, m_ill);
      @(posedge Clk);
      #1;
      if (clr) begin
        m_step = 1;
        m_halt = 0;
        m_ill = 0;
      end else if (!m_halt) begin
        if (m_step == 4 && op == 4'hF) m_halt = 1;
`ifdef SAP_1_CTRL_ILLEGAL_TRAP_EN
        else if (m_step == 4 && op inside {[4'h3:4'hD]}) begin
          m_halt = 1;
          m_ill = 1;
        end
`endif
        else m_step = (m_step == 6) ? 1 : m_step + 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
